// File: rtl/bus_pkg.sv
// Shared types and default geometry for the bus cycle controller.
package bus_pkg;

  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WAIT_MAX = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } bus_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational; last=1 means DMA won last.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Two-master T1/T2/T3/TW/T4 bus cycle engine; done lands in T4, 3 cycles after T1 plus one per wait state.
// Slave backpressure is READY (wait states, bounded by WAIT_MAX); requesters hold req until done.
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic                   err,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      Address,
  output logic                   CS,
  output logic                   ALE,
  output logic                   RD,
  output logic                   WR,
  output logic [DATA_W-1:0]      Dout,
  input  logic [DATA_W-1:0]      Din,
  input  logic                   READY
);

  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  bus_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] win;
  logic       sel;
  logic       strobe;

  rr_arbiter2 u_arb (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  assign sel = win[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_T1;
          owner_d = win;
          last_d  = sel;
          we_d    = req_we[sel];
          addr_d  = req_addr[sel];
          wdata_d = req_wdata[sel];
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (READY) begin
          state_d = S_T4;
          if (!we_q) rdata_d = Din;
        end else begin
          state_d = S_TW;
          cnt_d   = CNT_W'(1);
        end
      end
      S_TW: begin
        if (READY) begin
          state_d = S_T4;
          if (!we_q) rdata_d = Din;
        end else if (cnt_q >= CNT_MAX) begin
          // slave never answered: close the cycle and flag it
          state_d = S_T4;
          tmo_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = S_TW;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_T4: begin
        if (|req) begin
          state_d = S_T1;
          owner_d = win;
          last_d  = sel;
          we_d    = req_we[sel];
          addr_d  = req_addr[sel];
          wdata_d = req_wdata[sel];
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  assign strobe  = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);
  assign gnt     = (state_q == S_IDLE) ? 2'b00 : owner_q;
  assign done    = (state_q == S_T4) ? owner_q : 2'b00;
  assign err     = (state_q == S_T4) && tmo_q;
  assign rdata   = rdata_q;
  assign Address = addr_q;
  assign Dout    = wdata_q;
  assign CS      = (state_q != S_IDLE);
  assign ALE     = (state_q == S_T1);
  assign RD      = !(strobe && !we_q);
  assign WR      = !(strobe && we_q);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed and randomized bus cycles checked against a transaction-level model of arbitration and timing.
module tb_bus_cycle_ctrl;

  localparam int WAIT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       req_we;
  logic [1:0][19:0] req_addr;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             err;
  logic [7:0]       rdata;
  logic [19:0]      Address;
  logic             CS, ALE, RD, WR;
  logic [7:0]       Dout;
  logic [7:0]       Din;
  logic             READY;

  int n_checks = 0;
  int n_fail   = 0;
  int last_owner;

  bus_cycle_ctrl #(.ADDR_W(20), .DATA_W(8), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .Address   (Address),
    .CS        (CS),
    .ALE       (ALE),
    .RD        (RD),
    .WR        (WR),
    .Dout      (Dout),
    .Din       (Din),
    .READY     (READY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs"}, 32'(CS), 32'd0);
    check({tag, "_ale"}, 32'(ALE), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rd"}, 32'(RD), 32'd1);
    check({tag, "_wr"}, 32'(WR), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic go_idle(input int n);
    req = 2'b00;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_idle("idle");
    end
  endtask

  // Called at a negedge while the DUT is idle or in T4; returns at the negedge of T4.
  task automatic bus_txn(input logic [1:0] r, input logic [1:0] we,
                         input logic [19:0] a0, input logic [19:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input int waits, input logic [7:0] din, input bit drop);
    int         w;
    int         lat;
    bit         tmo;
    logic [1:0] exp_gnt;
    logic [19:0] exp_addr;
    logic [7:0] exp_wd;
    logic       exp_we;

    w          = (r == 2'b11) ? 1 - last_owner : (r[0] ? 0 : 1);
    last_owner = w;
    tmo        = waits > WAIT_MAX;
    lat        = 3 + (tmo ? WAIT_MAX : waits);
    exp_gnt    = 2'b01 << w;
    exp_addr   = (w == 1) ? a1 : a0;
    exp_wd     = (w == 1) ? d1 : d0;
    exp_we     = we[w];

    req          = r;
    req_we       = we;
    req_addr[0]  = a0;
    req_addr[1]  = a1;
    req_wdata[0] = d0;
    req_wdata[1] = d1;
    READY        = 1'($urandom);
    Din          = 8'($urandom);

    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("cs", 32'(CS), 32'd1);
      check("addr", 32'(Address), 32'(exp_addr));
      if (c == 0) begin
        check("t1_ale", 32'(ALE), 32'd1);
        check("t1_rd", 32'(RD), 32'd1);
        check("t1_wr", 32'(WR), 32'd1);
        check("t1_done", 32'(done), 32'd0);
      end else if (c < lat) begin
        check("strb_ale", 32'(ALE), 32'd0);
        check("strb_rd", 32'(RD), 32'(exp_we));
        check("strb_wr", 32'(WR), 32'(!exp_we));
        check("strb_done", 32'(done), 32'd0);
        check("strb_err", 32'(err), 32'd0);
        if (exp_we) check("dout", 32'(Dout), 32'(exp_wd));
      end else begin
        check("t4_done", 32'(done), 32'(exp_gnt));
        check("t4_err", 32'(err), 32'(tmo));
        check("t4_rd", 32'(RD), 32'd1);
        check("t4_wr", 32'(WR), 32'd1);
        check("t4_ale", 32'(ALE), 32'd0);
        if (!exp_we) check("rdata", 32'(rdata), tmo ? 32'd0 : 32'(din));
      end
      if (c < lat) begin
        // requester-side inputs wander after T1; the latched cycle must not follow them
        req_addr[0]  = 20'($urandom);
        req_addr[1]  = 20'($urandom);
        req_wdata[0] = 8'($urandom);
        req_wdata[1] = 8'($urandom);
        req_we       = 2'($urandom);
        if (drop) req = 2'b00;
        READY = (c >= 2) ? (c - 2 >= waits) : 1'($urandom);
        Din   = (c == lat - 1 && !tmo) ? din : 8'($urandom_range(1, 255));
      end
    end
  endtask

  initial begin
    int         waits;
    logic [1:0] r;

    rst          = 1'b1;
    req          = 2'b00;
    req_we       = 2'b00;
    req_addr[0]  = '0;
    req_addr[1]  = '0;
    req_wdata[0] = '0;
    req_wdata[1] = '0;
    Din          = '0;
    READY        = 1'b1;
    last_owner   = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr", 32'(Address), 32'd0);
    check("rst_dout", 32'(Dout), 32'd0);
    rst = 1'b0;

    // CPU zero-wait read
    bus_txn(2'b01, 2'b00, 20'h12345, 20'h0, 8'h00, 8'h00, 0, 8'hA5, 1'b0);
    go_idle(1);

    // DMA write with two wait states
    bus_txn(2'b10, 2'b10, 20'h00000, 20'hFFFFF, 8'h00, 8'h3C, 2, 8'h00, 1'b0);
    go_idle(1);

    // continuous tie: CPU, DMA, CPU back to back
    for (int i = 0; i < 3; i++) begin
      bus_txn(2'b11, 2'($urandom), 20'($urandom), 20'($urandom),
              8'($urandom), 8'($urandom), 0, 8'($urandom_range(1, 255)), 1'b0);
    end
    go_idle(1);

    // CPU read that times out
    bus_txn(2'b01, 2'b00, 20'h0BEEF, 20'h0, 8'h00, 8'h00, WAIT_MAX + 5, 8'h77, 1'b0);
    go_idle(1);

    // reset lands in T3 of a CPU write
    req          = 2'b01;
    req_we       = 2'b01;
    req_addr[0]  = 20'h0ABCD;
    req_wdata[0] = 8'h5A;
    READY        = 1'b0;
    last_owner   = 0;
    @(negedge clk);
    check("abort_t1_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort_t3_wr", 32'(WR), 32'd0);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check_idle("abort");
    rst        = 1'b0;
    last_owner = 1;
    @(negedge clk);
    check_idle("abort_post");
    bus_txn(2'b11, 2'b00, 20'h00111, 20'h00222, 8'h11, 8'h22, 1, 8'hC3, 1'b0);
    go_idle(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r     = 2'($urandom_range(1, 3));
      waits = ($urandom_range(0, 7) == 0) ? WAIT_MAX + 1 + $urandom_range(0, 3)
                                          : $urandom_range(0, 3);
      bus_txn(r, 2'($urandom), 20'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
              waits, 8'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 2));
    end
    go_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 20, meaning bus address width.
REQ-002 SHALL take parameter DATA_W, default 8, meaning bus data width.
REQ-003 SHALL take parameter WAIT_MAX, default 15, meaning the maximum number of wait states before timeout.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  [1:0]  per-requester cycle request; index 0 is the CPU, index 1 is the DMA.
REQ-007 SHALL have port req_we  input  [1:0]  per-requester write enable; 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  [1:0][ADDR_W-1:0]  per-requester address.
REQ-009 SHALL have port req_wdata  input  [1:0][DATA_W-1:0]  per-requester write data.
REQ-010 SHALL have port gnt  output  [1:0]  one-hot owner of the current cycle; held from T1 through T4.
REQ-011 SHALL have port done  output  [1:0]  one-cycle completion pulse to the owner.
REQ-012 SHALL have port err  output  1  one-cycle timeout pulse, coincident with done.
REQ-013 SHALL have port rdata  output  DATA_W  read data; valid while done=1.
REQ-014 SHALL have port Address  output  ADDR_W  bus address.
REQ-015 SHALL have ports CS, ALE, RD, WR  output  1 each  bus strobes; RD and WR are active-low.
REQ-016 SHALL have port Dout  output  DATA_W  bus write data.
REQ-017 SHALL have port Din  input  DATA_W  bus read data.
REQ-018 SHALL have port READY  input  1  bus slave ready; 1 = no wait.

Function
REQ-019 SHALL implement states IDLE, T1, T2, T3, TW, T4 as a registered FSM; the next-state logic SHALL assign every state in every branch.
REQ-020 IDLE SHALL move to T1 if any req is high, else stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: the requester not granted last wins a tie; after reset CPU has priority.
REQ-022 On entry to T1, address, we and wdata of the winner SHALL be latched; later changes to req inputs SHALL not affect the cycle.
REQ-023 T1 SHALL drive CS=1, ALE=1, Address=latched address, RD=WR=1.
REQ-024 T2 SHALL hold CS=1, set ALE=0, and drive RD=0 for a read or WR=0 plus Dout=latched wdata for a write.
REQ-025 T2 SHALL always advance to T3.
REQ-026 In T3 and TW, strobes SHALL be held; READY=1 SHALL move to T4, otherwise the FSM SHALL move to TW.
REQ-027 The wait counter (0..WAIT_MAX) SHALL increment per TW cycle; READY=0 with count==WAIT_MAX SHALL force T4 with err set.
REQ-028 Reads SHALL register Din into rdata on the T3/TW→T4 edge; on timeout, rdata SHALL be 0.
REQ-029 T4 SHALL deassert RD and WR (1), keep CS=1, assert done[owner] for one cycle, and pulse err if timed out.
REQ-030 T4 SHALL move to T1 if any req is high (back-to-back, re-arbitrated), else to IDLE.
REQ-031 Zero-wait latency SHALL be T1→done exactly 3 cycles later (T4); each wait state SHALL add one cycle.
REQ-032 Requesters SHALL hold req until done; a req dropped mid-cycle SHALL not abort the cycle.
REQ-033 In IDLE, CS, ALE and gnt SHALL be 0 and RD=WR=1.

Reset
REQ-034 rst SHALL force IDLE on the next edge from any state, including mid-cycle, without producing done or err.
REQ-035 Reset values SHALL be: gnt=0, done=0, err=0, rdata=0, Address=0, Dout=0, CS=0, ALE=0, RD=1, WR=1, wait count=0, last-grant=DMA (so CPU is favoured).

Structure
REQ-036 The state enum, ADDR_W, DATA_W and WAIT_MAX defaults SHALL live in shared package bus_pkg.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter2 (inputs: req[1:0], last; output: one-hot win); all other logic stays in bus_cycle_ctrl.

Verification
REQ-038 CPU read, addr 20'h12345, READY=1, Din=8'hA5 -> ALE in T1, RD low in T2–T3, done[0] 3 cycles after T1, rdata=8'hA5.
REQ-039 DMA write, addr 20'hFFFFF, wdata 8'h3C, READY=0 for 2 cycles -> WR low for 4 cycles, Dout=8'h3C, done[1] 5 cycles after T1, err=0.
REQ-040 req=2'b11 held continuously -> back-to-back cycles with grants alternating CPU, DMA, CPU and no IDLE between them.
REQ-041 READY held 0 -> 15 TW cycles, then T4 with done and err pulsing together, rdata=0.
REQ-042 rst asserted in T3 of a write -> next cycle IDLE, WR=1, CS=0, no done; the next request is granted to the CPU.
